// File: rtl/nx_fifo_pkg.sv
// Shared types and default widths for the nx_fifo read-side blocks.
package nx_fifo_pkg;

   localparam int NX_DATA_W = 64;
   localparam int NX_LEN_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/nx_skid2.sv
// Two-entry in-order output buffer: push from the FIFO head, pop on stream accept.
module nx_skid2 #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] ent0_q, ent0_d;
   logic [DATA_W-1:0] ent1_q, ent1_d;
   logic [1:0]        count_q, count_d;
   logic              do_push, do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   // A full buffer only takes a push when the same cycle frees a slot.
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (clear) begin
         count_d = 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) ent0_d = push_data;
               else                 ent1_d = push_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               ent0_d  = ent1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  ent0_d = push_data;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign data  = (count_q != 2'd0) ? ent0_q : '0;

endmodule

// File: rtl/nx_fifo_rd_stream.sv
// Reads a length-limited burst from a show-ahead FIFO and presents it as a
// valid/ready stream with last-beat marking, abort/flush and completion pulses.
module nx_fifo_rd_stream
   import nx_fifo_pkg::*;
#(
   parameter int DATA_W = NX_DATA_W,
   parameter int LEN_W  = NX_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              abort,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_ren,
   output logic              fifo_clear,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  beat_cnt,
   output rd_state_e         dbg_state
);

   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   rd_state_e         state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic              done_q, done_d;
   logic [1:0]        buf_count;
   logic [DATA_W-1:0] buf_data;
   logic              skid_push, skid_pop, skid_clear;
   logic              accept, last_beat;

   nx_skid2 #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (skid_clear),
      .push      (skid_push),
      .push_data (fifo_rdata),
      .pop       (skid_pop),
      .data      (buf_data),
      .count     (buf_count)
   );

   // Stream handshake: a beat transfers on a rising edge where m_valid and
   // m_ready are both 1; m_valid never drops and m_data never changes while
   // waiting for m_ready, except when an abort discards the whole buffer.
   assign m_valid   = (buf_count != 2'd0);
   assign m_data    = buf_data;
   assign last_beat = (beat_q == (len_q - ONE));
   assign m_last    = m_valid && last_beat;
   assign accept    = m_valid && m_ready;
   assign beat_cnt  = beat_q;
   assign done      = done_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start && (burst_len != '0)) state_d = ST_STREAM;
         ST_STREAM: begin
            if (abort)                 state_d = ST_FLUSH;
            else if (accept && m_last) state_d = ST_IDLE;
         end
         ST_FLUSH:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_ren   = 1'b0;
      fifo_clear = 1'b0;
      aborted    = 1'b0;
      skid_push  = 1'b0;
      skid_pop   = 1'b0;
      skid_clear = 1'b0;
      busy       = (state_q != ST_IDLE);
      case (state_q)
         ST_STREAM: begin
            // Abort wins over both a pending read and a same-cycle accept.
            fifo_ren   = !fifo_empty && (issued_q < len_q) &&
                         (buf_count != 2'd2) && !abort;
            skid_push  = fifo_ren;
            skid_pop   = accept && !abort;
            skid_clear = abort;
         end
         ST_FLUSH: begin
            fifo_clear = 1'b1;
            aborted    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      len_d    = len_q;
      issued_d = issued_q;
      beat_d   = beat_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  len_d    = burst_len;
                  issued_d = '0;
                  beat_d   = '0;
               end
            end
         end
         ST_STREAM: begin
            if (!abort) begin
               if (fifo_ren) issued_d = issued_q + ONE;
               if (accept)   beat_d   = beat_q + ONE;
               done_d = accept && m_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q    <= '0;
         issued_q <= '0;
         beat_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         len_q    <= len_d;
         issued_q <= issued_d;
         beat_q   <= beat_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Bench for nx_fifo_rd_stream: directed table, corner sequences and random traffic
// against a queue-based behavioural model of the burst reader.
module tb_nx_fifo_rd_stream;
   import nx_fifo_pkg::*;

   localparam int DW = 64;
   localparam int LW = 16;
   localparam int OW = DW + LW + 7;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, abort, fifo_empty, m_ready;
   logic [LW-1:0] burst_len;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_ren, fifo_clear, m_valid, m_last, busy, done, aborted;
   logic [DW-1:0] m_data;
   logic [LW-1:0] beat_cnt;
   rd_state_e     dbg_state;

   nx_fifo_rd_stream #(.DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
      .fifo_clear(fifo_clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .done(done), .aborted(aborted),
      .beat_cnt(beat_cnt), .dbg_state(dbg_state)
   );

   // ---------------- FIFO, scoreboard and model state ----------------
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];

   int            m_ph;       // 0 idle, 1 streaming, 2 flushing
   int unsigned   m_len, m_issued, m_acc;
   logic [DW-1:0] m_buf[$];
   logic          m_done;

   int n_vec, n_err;

   typedef struct {
      logic          start;
      logic [LW-1:0] len;
      logic          ready;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic          exp_last;
      logic          exp_ren;
      logic          exp_busy;
      logic          exp_done;
      logic [LW-1:0] exp_beat;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fifo_sync();
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? '0 : fifo_q[0];
   endtask

   task automatic model_reset();
      m_ph = 0; m_len = 0; m_issued = 0; m_acc = 0; m_done = 1'b0;
      m_buf.delete();
   endtask

   function automatic logic [OW-1:0] act_out();
      return {fifo_ren, fifo_clear, m_valid, m_data, m_last, busy, done, aborted, beat_cnt};
   endfunction

   function automatic logic [OW-1:0] exp_out();
      logic          v, l, r;
      logic [DW-1:0] d;
      v = (m_buf.size() > 0);
      d = v ? m_buf[0] : '0;
      l = v && (m_acc + 1 == m_len);
      r = (m_ph == 1) && (fifo_q.size() > 0) && (m_issued < m_len) &&
          (m_buf.size() < 2) && !abort;
      return {r, (m_ph == 2), v, d, l, (m_ph != 0), m_done, (m_ph == 2), LW'(m_acc)};
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_adv();
      logic          acc, r, nd;
      logic [OW-1:0] e;
      e   = exp_out();
      r   = e[OW-1];
      acc = (m_buf.size() > 0) && m_ready;
      nd  = 1'b0;
      case (m_ph)
         0: if (start) begin
            if (burst_len == 0) nd = 1'b1;
            else begin
               m_ph = 1; m_len = burst_len; m_issued = 0; m_acc = 0;
               m_buf.delete();
            end
         end
         1: if (abort) begin
            m_ph = 2;
            m_buf.delete();
         end else begin
            if (acc) begin
               void'(m_buf.pop_front());
               m_acc++;
               if (m_acc == m_len) begin nd = 1'b1; m_ph = 0; end
            end
            if (r) begin
               m_buf.push_back(fifo_q[0]);
               m_issued++;
            end
         end
         default: m_ph = 0;
      endcase
      m_done = nd;
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge with inputs already set.
   task automatic step(input string nm);
      logic ren_s, clr_s;
      #1;
      chk(nm, act_out(), exp_out());
      ren_s = fifo_ren;
      clr_s = fifo_clear;
      if (m_valid && m_ready && !abort) got_q.push_back(m_data);
      model_adv();
      @(posedge clk);
      #1;
      if (ren_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (clr_s) fifo_q.delete();
      fifo_sync();
      @(negedge clk);
   endtask

   task automatic run_until_idle(input string nm, input int budget);
      for (int k = 0; k < budget && (m_ph != 0 || m_done); k++) step(nm);
      #1;
      chk("idle_reached", OW'(busy), '0);
   endtask

   task automatic preload(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(base + DW'(i));
         exp_q.push_back(base + DW'(i));
      end
      fifo_sync();
   endtask

   task automatic check_order(input string nm);
      chk(nm, OW'(got_q.size()), OW'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(nm, OW'(got_q[i]), OW'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic start_burst(input logic [LW-1:0] len, input string nm);
      start = 1'b1; burst_len = len;
      step(nm);
      start = 1'b0; burst_len = '0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int ren_cnt;
      n_vec = 0; n_err = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; burst_len = '0;
      fifo_q.delete(); fifo_sync(); model_reset();

      repeat (2) @(negedge clk);
      #1;
      chk("reset_outs", act_out(), '0);
      chk("reset_state", OW'(dbg_state), OW'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      step("idle");

      // Directed burst of 4, ready held high.
      tbl[0] = '{1'b1, 16'd4, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 16'd0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 64'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 64'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 64'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
      tbl[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 64'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
      tbl[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd4};
      tbl[7] = '{1'b0, 16'd0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
      preload(64'hA0, 4);
      for (int i = 0; i < 8; i++) begin
         start = tbl[i].start; burst_len = tbl[i].len; m_ready = tbl[i].ready;
         #1;
         chk("tbl_vec",
             {1'b0, m_valid, m_data, m_last, fifo_ren, busy, done, beat_cnt},
             {1'b0, tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_last, tbl[i].exp_ren,
              tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_beat});
         step("tbl_model");
      end
      start = 1'b0;
      check_order("burst4_order");

      // Back-pressure: burst of 3 with ready low for 5 cycles.
      preload(64'hB0, 3);
      m_ready = 1'b0;
      start_burst(16'd3, "stall_start");
      ren_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         ren_cnt += int'(fifo_ren);
         if (i >= 1) chk("stall_hold", {m_valid, m_data}, {1'b1, 64'hB0});
         step("stall");
      end
      chk("stall_ren_count", OW'(ren_cnt), OW'(2));
      m_ready = 1'b1;
      run_until_idle("stall_drain", 50);
      check_order("stall_order");

      // FIFO runs dry after two entries for four cycles.
      preload(64'hC0, 2);
      start_burst(16'd8, "dry_start");
      step("dry_c1");
      step("dry_c2");
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("dry_no_ren", OW'(fifo_ren), '0);
         step("dry");
      end
      preload(64'hC2, 6);
      run_until_idle("dry_drain", 50);
      check_order("dry_order");

      // Abort after two accepted beats of a 6-beat burst.
      preload(64'hD0, 6);
      start_burst(16'd6, "abort_start");
      for (int k = 0; k < 20 && m_acc < 2; k++) step("abort_run");
      abort = 1'b1;
      step("abort_cycle");
      abort = 1'b0;
      #1;
      chk("abort_flush", {m_valid, fifo_clear, aborted, busy, done}, 5'b01110);
      step("flush");
      #1;
      chk("abort_after", {m_valid, fifo_clear, aborted, busy, done}, 5'b00000);
      step("post_abort");
      exp_q.delete(); exp_q.push_back(64'hD0); exp_q.push_back(64'hD1);
      check_order("abort_order");

      // Zero-length burst: done pulse only.
      preload(64'hE0, 1);
      exp_q.delete();
      start = 1'b1; burst_len = '0;
      #1;
      chk("zero_no_ren0", OW'(fifo_ren), '0);
      step("zero_start");
      start = 1'b0;
      #1;
      chk("zero_done", {done, fifo_ren, busy}, 3'b100);
      step("zero_done_cycle");
      #1;
      chk("zero_done_clear", OW'(done), '0);
      chk("zero_fifo_untouched", OW'(fifo_q.size()), OW'(1));
      fifo_q.delete(); fifo_sync();

      // Asynchronous reset in the middle of a burst.
      preload(64'hF0, 5);
      start_burst(16'd5, "rst_start");
      for (int k = 0; k < 20 && m_acc < 3; k++) step("rst_run");
      rst = 1'b1;
      #1;
      chk("rst_async_outs", act_out(), '0);
      model_reset();
      fifo_q.delete(); fifo_sync();
      got_q.delete(); exp_q.delete();
      step("rst_hold");
      step("rst_hold");
      rst = 1'b0;
      preload(64'h60, 2);
      start_burst(16'd2, "post_rst_start");
      run_until_idle("post_rst", 30);
      #1;
      chk("post_rst_beats", OW'(beat_cnt), OW'(2));
      check_order("post_rst_order");

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 5) == 0);
         burst_len = LW'($urandom_range(0, 12));
         abort     = ($urandom_range(0, 24) == 0);
         m_ready   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) begin
            fifo_q.push_back({$urandom, $urandom});
            fifo_sync();
         end
         step("random");
      end
      start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      for (int k = 0; k < 40 && m_ph == 1; k++) begin
         fifo_q.push_back({$urandom, $urandom});
         fifo_sync();
         step("random_drain");
      end
      run_until_idle("random_end", 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nx_fifo_rd_stream.md
NX_FIFO_RD_STREAM -- requirements
Module: nx_fifo_rd_stream

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64: data width; it SHALL match the paired FIFO.
REQ-002 The module SHALL have parameter LEN_W, default 16: width of the burst length and beat counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a burst.
REQ-006 The module SHALL have port burst_len, input, LEN_W bits: the number of beats to read; it is sampled with start.
REQ-007 The module SHALL have port abort, input, 1 bit: terminates the current burst.
REQ-008 The module SHALL have port fifo_empty, input, 1 bit: the empty flag from the show-ahead FIFO.
REQ-009 The module SHALL have port fifo_rdata, input, DATA_W bits: the FIFO head data, valid whenever fifo_empty=0.
REQ-010 The module SHALL have port fifo_ren, output, 1 bit: pops the FIFO head at the clock edge.
REQ-011 The module SHALL have port fifo_clear, output, 1 bit: a one-cycle FIFO flush.
REQ-012 The module SHALL have port m_valid, output, 1 bit: stream valid.
REQ-013 The module SHALL have port m_ready, input, 1 bit: stream ready.
REQ-014 The module SHALL have port m_data, output, DATA_W bits: stream data.
REQ-015 The module SHALL have port m_last, output, 1 bit: marks the final beat of the burst.
REQ-016 The module SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.
REQ-017 The module SHALL have port done, output, 1 bit: a one-cycle pulse on burst completion.
REQ-018 The module SHALL have port aborted, output, 1 bit: a one-cycle pulse on abort.
REQ-019 The module SHALL have port beat_cnt, output, LEN_W bits: the number of beats accepted downstream in the current burst.

Function
REQ-020 The state machine SHALL have three states: IDLE, STREAM and FLUSH.
REQ-021 In IDLE, start with burst_len>0 SHALL latch burst_len, clear the issue and beat counters, and move to STREAM.
REQ-022 In IDLE, start with burst_len=0 SHALL pulse done in the next cycle, perform no FIFO reads, and remain in IDLE.
REQ-023 The module SHALL ignore start when not in IDLE.
REQ-024 The module SHALL contain a 2-entry output buffer holding data captured from fifo_rdata on the same edge fifo_ren is asserted; the FIFO read therefore adds zero wait cycles.
REQ-025 fifo_ren SHALL equal (state=STREAM) AND NOT fifo_empty AND (issued<len) AND (buf_count<2) AND NOT abort.
REQ-026 fifo_ren SHALL never be asserted while fifo_empty=1, so the FIFO never sees an underflow.
REQ-027 m_valid SHALL equal (buf_count>0); m_data SHALL be the oldest buffer entry.
REQ-028 A beat SHALL be accepted when m_valid AND m_ready; a push and a pop in the same cycle SHALL leave buf_count unchanged.
REQ-029 With a non-empty FIFO and m_ready held at 1, sustained throughput SHALL be one beat per cycle, with the first m_valid one cycle after the STREAM entry edge.
REQ-030 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-031 m_last SHALL equal m_valid AND (beat_cnt = len-1).
REQ-032 Acceptance of the m_last beat SHALL pulse done in the next cycle and move the state to IDLE; beat_cnt SHALL then hold len until the next start.
REQ-033 Counters SHALL not wrap: issued SHALL saturate at len, and len up to 2^LEN_W-1 SHALL be supported.
REQ-034 abort in STREAM SHALL discard the buffer, move to FLUSH, and force m_valid=0 from the next cycle; abort SHALL take priority over a same-cycle accept.
REQ-035 FLUSH SHALL last exactly one cycle, assert fifo_clear=1 and aborted=1, then return to IDLE.
REQ-036 abort in IDLE or FLUSH SHALL have no effect.

Reset
REQ-037 Assertion of rst SHALL immediately force state=IDLE, buf_count=0, issued=0 and beat_cnt=0.
REQ-038 During and after reset, all outputs SHALL be 0 (fifo_ren, fifo_clear, m_valid, m_data, m_last, busy, done, aborted, beat_cnt).
REQ-039 Reset asserted mid-burst SHALL drop all buffered data without generating done or aborted.
REQ-040 The first start SHALL be honoured in the cycle after rst deasserts.

Structure
REQ-041 The state enum (IDLE/STREAM/FLUSH) and the default DATA_W/LEN_W constants SHALL reside in the shared nx_fifo package.
REQ-042 The 2-entry buffer SHALL be a sub-module nx_skid2 (push, pop, data, count); the FSM and counters SHALL live in the top module.

Verification
REQ-043 The bench SHALL apply start with burst_len=4, a FIFO preloaded with A0..A3, and m_ready=1, and SHALL check 4 beats on consecutive cycles, m_last on A3, done one cycle later, and beat_cnt=4.
REQ-044 The bench SHALL apply burst_len=3 with m_ready low for 5 cycles and SHALL check exactly 2 fifo_ren pulses, m_data stable, and no data loss once ready returns.
REQ-045 The bench SHALL apply burst_len=8 with a FIFO that empties after 2 entries for 4 cycles and SHALL check fifo_ren=0 while empty and the burst completing with correct order.
REQ-046 The bench SHALL assert abort after beat 2 of burst_len=6 and SHALL check m_valid=0 next cycle, one-cycle fifo_clear and aborted, no done, and busy=0 after FLUSH.
REQ-047 The bench SHALL apply start with burst_len=0 and SHALL check a done pulse with no fifo_ren.
REQ-048 The bench SHALL assert rst mid-burst (beat_cnt=3) and SHALL check all outputs 0 immediately and a new burst_len=2 burst completing correctly.
